// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide DataMemory port between the
// instruction cache (req0) and the data cache (req1). Each granted request
// becomes exactly one memory transaction. The refill line goes back to its
// owner only. Round-robin tie-break keeps either cache from starving.
module mem_port_arbiter #(
    parameter  int LINE_SIZE = 16,
    localparam int W         = LINE_SIZE * 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0_valid,
    input  logic [31:0]   req0_addr,
    input  logic          req0_read,
    input  logic          req0_write,
    input  logic [W-1:0]  req0_din,
    output logic          req0_grant,
    output logic          req0_done,
    output logic [W-1:0]  req0_dout,

    input  logic          req1_valid,
    input  logic [31:0]   req1_addr,
    input  logic          req1_read,
    input  logic          req1_write,
    input  logic [W-1:0]  req1_din,
    output logic          req1_grant,
    output logic          req1_done,
    output logic [W-1:0]  req1_dout,

    output logic          mem_is_input_valid,
    output logic [31:0]   mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [W-1:0]  mem_din,
    input  logic          mem_is_output_valid,
    input  logic [W-1:0]  mem_dout,
    input  logic          mem_ready
);

    // DONE is a separate state so that arbitration never overlaps the
    // completion pulse: the next grant is at the earliest the cycle after done.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic           last_grant;   // requester granted most recently
    logic           owner;        // requester that owns the in-flight transaction
    logic [31:0]    hold_addr;
    logic           hold_read;
    logic           hold_write;
    logic [W-1:0]   hold_din;

    logic           legal0, legal1;
    logic           grant_any;    // a request is latched this cycle
    logic           pick;         // which requester wins when grant_any

    // A request is legal only with exactly one of read/write set.
    assign legal0 = req0_valid && (req0_read ^ req0_write);
    assign legal1 = req1_valid && (req1_read ^ req1_write);

    // Arbitration: a single legal requester wins outright; on a tie the one
    // that was not granted last time wins.
    always_comb begin
        grant_any = 1'b0;
        pick      = 1'b0;
        if (state == IDLE && !reset && mem_ready && (legal0 || legal1)) begin
            grant_any = 1'b1;
            if (legal0 && legal1)
                pick = ~last_grant;
            else
                pick = legal1;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt          = state;
        req0_grant         = grant_any && !pick;
        req1_grant         = grant_any && pick;
        req0_done          = 1'b0;
        req1_done          = 1'b0;
        mem_is_input_valid = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_din            = '0;
        case (state)
            IDLE: begin
                if (grant_any)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_is_input_valid = 1'b1;
                mem_read           = hold_read;
                mem_write          = hold_write;
                mem_din            = hold_din;
                // mem_ready is deliberately ignored here; the memory may still
                // be reporting ready from before it accepted this request.
                state_nxt          = hold_read ? WAIT_RD : WAIT_WR;
            end
            WAIT_RD: begin
                mem_read = hold_read;
                mem_din  = hold_din;
                if (mem_is_output_valid)
                    state_nxt = DONE;
            end
            WAIT_WR: begin
                mem_write = hold_write;
                mem_din   = hold_din;
                if (mem_ready)
                    state_nxt = DONE;
            end
            DONE: begin
                req0_done = !owner;
                req1_done = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The address bus keeps the last latched address even while idle.
    assign mem_addr = hold_addr;

    // State register, round-robin pointer and request holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            hold_addr  <= '0;
            hold_read  <= 1'b0;
            hold_write <= 1'b0;
            hold_din   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                owner      <= pick;
                last_grant <= pick;
                hold_addr  <= pick ? req1_addr  : req0_addr;
                hold_read  <= pick ? req1_read  : req0_read;
                hold_write <= pick ? req1_write : req0_write;
                hold_din   <= pick ? req1_din   : req0_din;
            end
        end
    end

    // Refill capture: only the owner's line register changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            req0_dout <= '0;
            req1_dout <= '0;
        end else if (state == WAIT_RD && mem_is_output_valid) begin
            if (owner)
                req1_dout <= mem_dout;
            else
                req0_dout <= mem_dout;
        end
    end

endmodule
